// File: rtl/dmem_line_responder_pkg.sv
// dmem_resp_pkg: shared types and address field helpers for the data-memory line responder.
package dmem_resp_pkg;
  typedef enum logic [1:0] {IDLE, RESP, WB, FILL} state_t;
  localparam int OFFSET_BITS = 5;
  localparam int TAG_W = 27;
  typedef logic [7:0][3:0][7:0] line_t;
  function automatic logic [TAG_W-1:0] tag_of(input logic [31:0] a);
    return a[31:OFFSET_BITS];
  endfunction
  function automatic logic [2:0] word_of(input logic [31:0] a);
    return a[4:2];
  endfunction
  function automatic logic [1:0] beat_of(input logic [31:0] a);
    return a[4:3];
  endfunction
endpackage

// File: rtl/dmem_line_responder_if.sv
// dmem_line_responder_if: cpu-side request/response and burst-memory signals of the responder.
interface dmem_line_responder_if;
  logic [31:0] dmem_address;
  logic [3:0]  dmem_rmask;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic [31:0] bmem_address;
  logic        bmem_read;
  logic        bmem_write;
  logic [63:0] bmem_wdata;
  logic [63:0] bmem_rdata;
  logic        bmem_resp;
  modport slave (
    input  dmem_address, dmem_rmask, dmem_wmask, dmem_wdata, bmem_rdata, bmem_resp,
    output dmem_rdata, dmem_resp, bmem_address, bmem_read, bmem_write, bmem_wdata
  );
  modport master (
    output dmem_address, dmem_rmask, dmem_wmask, dmem_wdata, bmem_rdata, bmem_resp,
    input  dmem_rdata, dmem_resp, bmem_address, bmem_read, bmem_write, bmem_wdata
  );
endinterface

// File: rtl/dmem_line_responder_line_buffer.sv
// line_buffer: 32-byte line storage with byte-enabled word writes and 64-bit beat access.
module line_buffer
  import dmem_resp_pkg::*;
(
  input  logic        clk,
  input  logic [3:0]  word_be,
  input  logic [2:0]  word_idx,
  input  logic [31:0] word_wdata,
  input  logic        beat_we,
  input  logic [1:0]  beat_idx,
  input  logic [63:0] beat_wdata,
  output logic [31:0] word_rdata,
  output logic [63:0] beat_rdata
);
  line_t data_q, data_d;
  always_comb begin
    data_d = data_q;
    for (int i = 0; i < 4; i++)
      if (word_be[i]) data_d[word_idx][i] = word_wdata[8*i +: 8];
    if (beat_we) begin
      data_d[{beat_idx, 1'b1}] = beat_wdata[63:32];
      data_d[{beat_idx, 1'b0}] = beat_wdata[31:0];
    end
  end
  always_ff @(posedge clk) data_q <= data_d;
  assign word_rdata = data_q[word_idx];
  assign beat_rdata = {data_q[{beat_idx, 1'b1}], data_q[{beat_idx, 1'b0}]};
endmodule

// File: rtl/dmem_line_responder.sv
// dmem_line_responder: single-line write-back buffer serving cpu loads/stores over a 4-beat burst port.
module dmem_line_responder
  import dmem_resp_pkg::*;
#(
  parameter int          BEAT_W   = 64,
  parameter int          BEATS    = 4,
  parameter logic [31:0] RST_ADDR = 32'h0000_0000
) (
  input logic clk,
  input logic rst,
  dmem_line_responder_if.slave bus
);
  localparam int CNT_W = $clog2(BEATS);
  state_t state_q, state_d;
  logic valid_q, valid_d, dirty_q, dirty_d;
  logic [TAG_W-1:0] tag_q, tag_d, req_tag;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d, word_rdata;
  logic [BEAT_W-1:0] beat_rdata;
  logic [3:0] word_be;
  logic beat_we, req, hit, last, unused_addr;
  assign unused_addr = ^bus.dmem_address[1:0];
  assign req_tag = tag_of(bus.dmem_address);
  assign req = (|bus.dmem_rmask) | (|bus.dmem_wmask);
  assign hit = valid_q && (tag_q == req_tag);
  assign last = cnt_q == CNT_W'(BEATS - 1);
  // a combined read+write returns the word as it was before this edge's byte update
  line_buffer u_line (
    .clk       (clk),
    .word_be   (word_be & {4{rst}}),
    .word_idx  (word_of(bus.dmem_address)),
    .word_wdata(bus.dmem_wdata),
    .beat_we   (beat_we & rst),
    .beat_idx  (cnt_q),
    .beat_wdata(bus.bmem_rdata),
    .word_rdata(word_rdata),
    .beat_rdata(beat_rdata)
  );
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    word_be = '0;
    beat_we = 1'b0;
    case (state_q)
      IDLE: if (req) begin
        if (hit) begin
          word_be = bus.dmem_wmask;
          dirty_d = dirty_q | (|bus.dmem_wmask);
          rdata_d = word_rdata;
          state_d = RESP;
        end else state_d = (valid_q && dirty_q) ? WB : FILL;
      end
      RESP: state_d = IDLE;
      WB: if (bus.bmem_resp) begin
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          cnt_d   = '0;
          dirty_d = 1'b0;
          state_d = FILL;
        end
      end
      FILL: if (bus.bmem_resp) begin
        beat_we = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (last) begin
          cnt_d   = '0;
          tag_d   = req_tag;
          valid_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      dirty_q <= 1'b0;
      tag_q   <= RST_ADDR[31:OFFSET_BITS];
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end
  assign bus.dmem_resp    = state_q == RESP;
  assign bus.dmem_rdata   = rdata_q;
  assign bus.bmem_read    = state_q == FILL;
  assign bus.bmem_write   = state_q == WB;
  assign bus.bmem_address = (state_q == WB)   ? {tag_q, 5'b0} :
                            (state_q == FILL) ? {req_tag, 5'b0} : '0;
  assign bus.bmem_wdata   = (state_q == WB) ? beat_rdata : '0;
endmodule

// File: doc/dmem_line_responder.md
Name: dmem_line_responder

Overview:
- Responder end of the pipeline's data-memory port. It serves word/half/byte requests (address, rmask, wmask, wdata) from the datapath and returns rdata with a one-cycle resp pulse.
- It is backed by a single-entry, 32-byte write-back line buffer.
- On a miss it writes back the dirty line and fills the new line over a 64-bit, 4-beat burst memory port.
- It sits between the cpu datapath and the burst memory/arbiter.

Parameters:
- BEAT_W, 64, burst data width in bits.
- BEATS, 4, beats per line (line = BEAT_W*BEATS = 256 bits).
- RST_ADDR, 32'h0000_0000, tag loaded at reset (entry is invalid regardless).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low (rst==0 resets on the clock edge).
- dmem_address  in  32  byte address; bits [1:0] ignored, the byte lanes come from the masks.
- dmem_rmask  in  4  byte read enables; nonzero means read request.
- dmem_wmask  in  4  byte write enables; nonzero means write request.
- dmem_wdata  in  32  write data, already lane-aligned by the requester.
- dmem_rdata  out  32  full addressed word; valid only while dmem_resp=1.
- dmem_resp  out  1  one-cycle completion pulse.
- bmem_address  out  32  line-aligned burst address ([4:0]=0).
- bmem_read  out  1  burst read request, held for the whole burst.
- bmem_write  out  1  burst write request, held for the whole burst.
- bmem_wdata  out  64  write beat data.
- bmem_rdata  in  64  read beat data.
- bmem_resp  in  1  per-beat acknowledge.

Behaviour:
- Line fields: tag = address[31:5]; word index = address[4:2]; beat index = address[4:3].
- Request rules:
  - A request is pending when (|rmask)|(|wmask).
  - The requester holds all request inputs stable until the cycle dmem_resp=1, and changes them only after that edge.
  - If rmask and wmask are both nonzero, the write takes effect and dmem_rdata returns the pre-write word.
- Reset (rst==0 at an edge, including mid-burst):
  - state=IDLE, valid=0, dirty=0, beat counter=0.
  - dmem_resp=0, bmem_read=0, bmem_write=0, bmem_address=0, dmem_rdata=0, bmem_wdata=0, all by the next cycle.
  - The line data is not cleared.
- IDLE:
  - No request: stay in IDLE.
  - Request and hit (valid && tag match): apply the wmask bytes at the edge (dirty<=1 if wmask!=0), register the read word into dmem_rdata, go to RESP.
  - Request, miss, and valid&&dirty: go to WB.
  - Request, miss, otherwise: go to FILL.
- RESP:
  - dmem_resp=1 for exactly this cycle, then IDLE.
  - Hit latency: request seen in cycle N, resp in cycle N+1.
- WB:
  - bmem_write=1, bmem_address={stored tag,5'b0}, bmem_wdata=line beat[cnt].
  - Each bmem_resp increments cnt. On the resp with cnt==BEATS-1: cnt<=0, dirty<=0, go to FILL.
- FILL:
  - bmem_read=1, bmem_address={request tag,5'b0}.
  - Each bmem_resp writes bmem_rdata into beat[cnt] and increments cnt. On the last beat: cnt<=0, tag<=request tag, valid<=1, go to IDLE, where the request re-evaluates as a hit.
- Requests in WB/FILL are not re-sampled; the held request is used.
- bmem_resp outside WB/FILL is ignored.
- bmem_read and bmem_write are never both 1.
- The beat counter wraps only via the last-beat rule.
- dmem_resp is never asserted in IDLE, WB, or FILL.

Decomposition:
- Package dmem_resp_pkg:
  - state enum {IDLE, RESP, WB, FILL}.
  - OFFSET_BITS=5, TAG_W=27, line_t (256-bit) typedef.
  - tag/beat/word field-extract functions.
- Sub-module line_buffer: 256-bit storage with byte-enabled word write, 64-bit beat write, word read, and beat read.
- The FSM, tag/valid/dirty, and counter live in dmem_line_responder.

Test Plan:
- Cold read: after reset, rmask=4'hF @0x1000_0004; memory returns beats 0x11..,0x22..,0x33..,0x44.. (1-cycle bmem_resp) -> one 4-beat read @0x1000_0000, no write burst, dmem_rdata=upper half of beat0, single resp pulse.
- Hit read: immediately read 0x1000_001C -> resp exactly 1 cycle after request, rdata=beat3[63:32], bmem idle.
- Byte write hit: wmask=4'b0100, wdata=0x00AB_0000 @0x1000_0000, then lw @0x1000_0000 -> byte 2 = 0xAB, other bytes unchanged, dirty set.
- Dirty eviction: lw @0x2000_0000 -> 4-beat write @0x1000_0000 (beat0 carries 0xAB in byte 2), then 4-beat read @0x2000_0000, resp after the fill, bmem_read/bmem_write never overlap.
- Stalled memory: bmem_resp delayed 5 cycles per beat -> bmem_read and bmem_address held steady, cnt advances only on resp, no dmem_resp during the burst.
- Reset mid-fill: rst=0 during FILL beat 2 -> next cycle bmem_read=0, dmem_resp=0; a repeated request afterwards misses (valid=0) and refills all 4 beats.
